// File: rtl/program_store.sv
// -----------------------------------------------------------------------------
// program_store
//   Writable instruction store for the MiniAlu-class core. A registered fetch
//   port returns mem[iAddress] one cycle after the address is presented. A
//   byte-wide load port, most significant byte first, assembles instructions
//   and writes them one after another from a programmable base address.
//   While a load session is open, fetch returns HOLD_WORD so the core idles.
//
// Ports
//   Clock        rising-edge clock
//   Reset        asynchronous, active-low reset
//   iAddress     fetch address
//   oInstruction registered fetch data
//   iLoadStart   pulse: open or restart a load session (sampled with iLoadBase)
//   iLoadBase    first write address of the session
//   iLoadValid   iLoadByte is valid
//   iLoadByte    load data, MSB of each instruction first
//   oLoadReady   byte accepted when iLoadValid && oLoadReady
//   iLoadEnd     pulse: close the session
//   oLoading     session active
//   oLoadCount   words committed in the current or last session
//   oOverflow    sticky: a completed word was dropped past the top address
// -----------------------------------------------------------------------------
module program_store #(
  parameter int INSN_WIDTH = 28,
  parameter int ADDR_WIDTH = 8,
  // Top nibble is the opcode field: LED (4'h7) with pattern 8'b10101010.
  parameter logic [INSN_WIDTH-1:0] FILL_WORD = 28'h70000AA,
  // NOP opcode (4'h0) with a zero operand field.
  parameter logic [INSN_WIDTH-1:0] HOLD_WORD = 28'h0000000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [INSN_WIDTH-1:0] oInstruction,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadBase,
  input  logic                  iLoadValid,
  input  logic [7:0]            iLoadByte,
  output logic                  oLoadReady,
  input  logic                  iLoadEnd,
  output logic                  oLoading,
  output logic [ADDR_WIDTH:0]   oLoadCount,
  output logic                  oOverflow
);

  localparam int NBYTES = (INSN_WIDTH + 7) / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int ASM_W  = INSN_WIDTH - 8;   // bits carried over from earlier bytes
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

  typedef enum logic {IDLE, LOAD} state_e;

  state_e                  state_q,  state_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;
  logic [ASM_W-1:0]        asm_q,    asm_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic                    full_q,   full_d;
  logic [ADDR_WIDTH:0]     count_q,  count_d;
  logic                    ovf_q,    ovf_d;
  logic [INSN_WIDTH-1:0]   insn_q,   insn_d;

  logic                    mem_we;
  logic [INSN_WIDTH-1:0]   word;
  logic [INSN_WIDTH-1:0]   rd_data;

  // Words are stored XOR-ed with FILL_WORD so that the all-zero power-up state
  // of the array reads back as FILL_WORD without any initialisation pass.
  logic [INSN_WIDTH-1:0]   mem_q [DEPTH];

  assign rd_data = mem_q[iAddress] ^ FILL_WORD;

  // Concatenation is exactly INSN_WIDTH wide, so the pad bits of the first
  // byte fall off the top of asm_q as later bytes shift in.
  assign word = {asm_q, iLoadByte};

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    insn_d   = (state_q == LOAD) ? HOLD_WORD : rd_data;

    if (iLoadStart) begin
      // Opening and restarting are identical; start wins over a same-cycle end
      // and discards any byte presented with it.
      state_d  = LOAD;
      wr_ptr_d = iLoadBase;
      idx_d    = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      full_d   = 1'b0;
    end else if (state_q == LOAD) begin
      if (iLoadValid) begin
        asm_d = word[ASM_W-1:0];
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            count_d  = count_q + (ADDR_WIDTH + 1)'(1);
            full_d   = (wr_ptr_q == TOP_ADDR);
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      // The byte above is handled first; a partial word is simply dropped.
      if (iLoadEnd) begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      asm_q    <= '0;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      insn_q   <= FILL_WORD;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      insn_q   <= insn_d;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM and so committed
  // words survive a reset that abandons a session.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= word ^ FILL_WORD;
    end
  end

  assign oInstruction = insn_q;
  assign oLoading     = (state_q == LOAD);
  assign oLoadReady   = (state_q == LOAD);
  assign oLoadCount   = count_q;
  assign oOverflow    = ovf_q;

endmodule

// File: tb/tb_program_store.sv
// -----------------------------------------------------------------------------
// tb_program_store
//   Directed bench for program_store with a 16-word store (ADDR_WIDTH=4).
//   A byte-queue reference model predicts every output each cycle; literal
//   expectations pin key results of the scenarios.
// -----------------------------------------------------------------------------
module tb_program_store;

  localparam int IW = 28;
  localparam int AW = 4;
  localparam logic [IW-1:0] FILL = 28'h70000AA;
  localparam logic [IW-1:0] HOLD = 28'h0000000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [IW-1:0] insn;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic          vld = 1'b0;
  logic [7:0]    byt = '0;
  logic          ready;
  logic          endp = 1'b0;
  logic          loading;
  logic [AW:0]   count;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;

  program_store #(
    .INSN_WIDTH(IW),
    .ADDR_WIDTH(AW),
    .FILL_WORD (FILL),
    .HOLD_WORD (HOLD)
  ) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .iAddress    (addr),
    .oInstruction(insn),
    .iLoadStart  (start),
    .iLoadBase   (base),
    .iLoadValid  (vld),
    .iLoadByte   (byt),
    .oLoadReady  (ready),
    .iLoadEnd    (endp),
    .oLoading    (loading),
    .oLoadCount  (count),
    .oOverflow   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [IW-1:0] m_mem [16];
  logic [IW-1:0] m_insn    = FILL;
  bit            m_loading = 1'b0;
  int            m_ptr     = 0;
  int            m_count   = 0;
  bit            m_ovf     = 1'b0;
  logic [7:0]    m_bytes[$];

  task automatic model_step();
    logic [31:0] w;
    if (!rst_n) begin
      m_loading = 1'b0;
      m_count   = 0;
      m_ovf     = 1'b0;
      m_insn    = FILL;
      m_bytes.delete();
      return;
    end
    m_insn = m_loading ? HOLD : m_mem[addr];
    if (start) begin
      m_loading = 1'b1;
      m_ptr     = int'(base);
      m_count   = 0;
      m_ovf     = 1'b0;
      m_bytes.delete();
    end else if (m_loading) begin
      if (vld) begin
        m_bytes.push_back(byt);
        if (m_bytes.size() == 4) begin
          w = '0;
          foreach (m_bytes[i]) w = (w << 8) | 32'(m_bytes[i]);
          if (m_ptr < 16) begin
            m_mem[m_ptr] = w[IW-1:0];
            m_ptr++;
            m_count++;
          end else begin
            m_ovf = 1'b1;
          end
          m_bytes.delete();
        end
      end
      if (endp) begin
        m_loading = 1'b0;
        m_bytes.delete();
      end
    end
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = FILL;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Every falling edge: outputs against the model.
  always @(negedge clk) begin
    check("insn",    32'(insn),    32'(m_insn));
    check("loading", 32'(loading), 32'(m_loading));
    check("ready",   32'(ready),   32'(m_loading));
    check("count",   32'(count),   32'(m_count));
    check("ovf",     32'(ovf),     32'(m_ovf));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    vld = 1'b1;
    byt = b;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic start_at(input logic [AW-1:0] b);
    start = 1'b1;
    base  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_pulse();
    endp = 1'b1;
    @(negedge clk);
    endp = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [AW-1:0] a, input logic [IW-1:0] exp);
    addr = a;
    @(negedge clk);
    check(name, 32'(insn), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset asserted between edges; outputs follow at once.
    #2 rst_n = 1'b0;
    #1;
    check("rst_insn",  32'(insn),    32'(FILL));
    check("rst_load",  32'(loading), 32'd0);
    check("rst_ready", 32'(ready),   32'd0);
    check("rst_count", 32'(count),   32'd0);
    check("rst_ovf",   32'(ovf),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 4'd5;
    @(negedge clk);
    check("post_rst_fetch0", 32'(insn), 32'(FILL));
    @(negedge clk);
    check("post_rst_fetch1", 32'(insn), 32'(FILL));

    // Basic load of two words at base 3.
    start_at(4'd3);
    check("basic_loading", 32'(loading), 32'd1);
    send(8'h01);
    check("basic_hold", 32'(insn), 32'(HOLD));
    send(8'h23); send(8'h45); send(8'h67);
    send(8'h89); send(8'hAB); send(8'hCD); send(8'hEF);
    end_pulse();
    check("basic_count", 32'(count), 32'd2);
    check("model_mem3", 32'(m_mem[3]), 32'h1234567);
    fetch("basic_mem3", 4'd3, 28'h1234567);
    fetch("basic_mem4", 4'd4, 28'h9ABCDEF);

    // Partial word at end, then last byte together with end.
    start_at(4'd6);
    send(8'h11); send(8'h22); send(8'h33);
    end_pulse();
    check("partial_count", 32'(count), 32'd0);
    fetch("partial_mem6", 4'd6, FILL);
    start_at(4'd6);
    send(8'hA1); send(8'hB2); send(8'hC3);
    vld = 1'b1; byt = 8'hD4; endp = 1'b1;
    @(negedge clk);
    vld = 1'b0; endp = 1'b0;
    check("endbyte_count", 32'(count), 32'd1);
    check("endbyte_idle", 32'(loading), 32'd0);
    fetch("endbyte_mem6", 4'd6, 28'h1B2C3D4);

    // Top boundary: three words from base 14.
    start_at(4'd14);
    send(8'h0F); send(8'h00); send(8'h00); send(8'h01);
    send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    send(8'h06); send(8'h07); send(8'h08); send(8'h09);
    end_pulse();
    check("ovf_count", 32'(count), 32'd2);
    check("ovf_flag",  32'(ovf),   32'd1);
    check("model_ovf", 32'(m_ovf), 32'd1);
    fetch("ovf_mem14", 4'd14, 28'hF000001);
    fetch("ovf_mem15", 4'd15, 28'h2030405);
    fetch("ovf_mem0",  4'd0,  FILL);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Restart with a same-cycle end.
    start_at(4'd0);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h50);
    start = 1'b1; base = 4'd8; endp = 1'b1;
    @(negedge clk);
    start = 1'b0; endp = 1'b0;
    check("restart_loading", 32'(loading), 32'd1);
    check("restart_count",   32'(count),   32'd0);
    check("restart_ovf",     32'(ovf),     32'd0);
    send(8'h8A); send(8'hBC); send(8'hDE); send(8'hF1);
    end_pulse();
    check("restart_count1", 32'(count), 32'd1);
    fetch("restart_mem0", 4'd0, 28'h0203040);
    fetch("restart_mem1", 4'd1, FILL);
    fetch("restart_mem8", 4'd8, 28'hABCDEF1);

    // Reset in the middle of a session.
    start_at(4'd10);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h9A); send(8'hBC);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_loading", 32'(loading), 32'd0);
    check("midrst_count",   32'(count),   32'd0);
    check("midrst_insn",    32'(insn),    32'(FILL));
    @(negedge clk);
    rst_n = 1'b1;
    fetch("midrst_mem10", 4'd10, 28'h2345678);
    fetch("midrst_mem11", 4'd11, FILL);

    // Bytes and end while idle are ignored.
    vld = 1'b1; byt = 8'h55; endp = 1'b1;
    @(negedge clk);
    vld = 1'b0; endp = 1'b0;
    check("idle_ignored_count", 32'(count), 32'd0);
    fetch("idle_mem10", 4'd10, 28'h2345678);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
